dsm_decimator: RTL and testbench

DSM_DECIMATOR -- requirements
Module: dsm_decimator

---
 rtl/dsm_decimator.sv | 109 ++++++++++
 tb/tb_dsm_decimator.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/dsm_decimator.sv
// Second-order CIC (sinc^2) decimator for a ternary PWM/delta-sigma bitstream.
// Integrators run on accepted samples; the comb and output stages follow each decimation edge.
module dsm_decimator #(
  parameter int unsigned OSR_LOG2 = 5
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               in_en,
  input  logic [1:0]         pwm,
  output logic signed [10:0] dout,
  output logic               dout_valid,
  input  logic               dout_ready,
  output logic               ovf,
  output logic               err
);

  localparam int unsigned W     = 2 * OSR_LOG2 + 2;
  localparam int unsigned SHIFT = 2 * OSR_LOG2 - 10;

  localparam logic signed [W-1:0] SAT_HI = W'(1023);
  localparam logic signed [W-1:0] SAT_LO = W'(-1024);

  logic signed [W-1:0]  sample;
  logic signed [W-1:0]  integ1;
  logic signed [W-1:0]  integ2;
  logic signed [W-1:0]  integ1_next;
  logic signed [W-1:0]  cap;
  logic signed [W-1:0]  cap_prev;
  logic signed [W-1:0]  comb1;
  logic signed [W-1:0]  comb1_prev;
  logic signed [W-1:0]  comb2;
  logic signed [W-1:0]  shifted;
  logic signed [10:0]   scaled;
  logic [OSR_LOG2-1:0]  phase;
  logic                 cap_pend;
  logic                 load_pend;

  always_comb begin
    sample = '0;
    case (pwm)
      2'b01:   sample = {{(W-1){1'b0}}, 1'b1};
      2'b11:   sample = '1;
      default: sample = '0;
    endcase
  end

  // Integrator 2 accumulates the freshly updated integrator 1, giving DC gain R^2
  // and letting the decimation-edge sample land in the value captured one edge later.
  assign integ1_next = integ1 + sample;

  always_comb begin
    comb1   = cap - cap_prev;
    comb2   = comb1 - comb1_prev;
    shifted = comb2 >>> SHIFT;
    scaled  = shifted[10:0];
    if (shifted > SAT_HI) begin
      scaled = 11'sd1023;
    end else if (shifted < SAT_LO) begin
      scaled = -11'sd1024;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      integ1     <= '0;
      integ2     <= '0;
      phase      <= '0;
      cap        <= '0;
      cap_prev   <= '0;
      comb1_prev <= '0;
      cap_pend   <= 1'b0;
      load_pend  <= 1'b0;
      dout       <= '0;
      dout_valid <= 1'b0;
      ovf        <= 1'b0;
      err        <= 1'b0;
    end else begin
      if (in_en) begin
        integ1 <= integ1_next;
        integ2 <= integ2 + integ1_next;
        phase  <= phase + 1'b1;
        if (pwm == 2'b10) begin
          err <= 1'b1;
        end
      end

      // Pipeline flags advance every cycle, so in_en stalls never hold a word in flight.
      cap_pend  <= in_en && (phase == '1);
      load_pend <= cap_pend;

      if (cap_pend) begin
        cap <= integ2;
      end

      if (load_pend) begin
        cap_prev   <= cap;
        comb1_prev <= comb1;
        dout       <= scaled;
        dout_valid <= 1'b1;
        if (dout_valid && !dout_ready) begin
          ovf <= 1'b1;
        end
      end else if (dout_valid && dout_ready) begin
        dout_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_dsm_decimator.sv
// Directed bench for dsm_decimator at OSR_LOG2=5: vector table of steady patterns
// plus hand sequences for error flag, overwrite, and mid-run reset.
module tb_dsm_decimator;

  logic              clk;
  logic              reset;
  logic              in_en;
  logic [1:0]        pwm;
  logic signed [10:0] dout;
  logic              dout_valid;
  logic              dout_ready;
  logic              ovf;
  logic              err;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int words[$];
  int stamps[$];

  typedef struct {
    logic [1:0] a;
    logic [1:0] b;
    bit         half;
    int         w1;
    int         w2;
    int         w3;
    int         gap;
  } vec_t;

  vec_t vecs[7];

  dsm_decimator #(.OSR_LOG2(5)) dut (
    .clock      (clk),
    .reset      (reset),
    .in_en      (in_en),
    .pwm        (pwm),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .ovf        (ovf),
    .err        (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    cyc++;
    if (dout_valid && dout_ready) begin
      words.push_back(int'(dout));
      stamps.push_back(cyc);
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int word_at(input int i);
    return (words.size() > i) ? words[i] : 32'h7fffffff;
  endfunction

  function automatic int gap_at(input int i);
    return (stamps.size() > i) ? (stamps[i] - stamps[i-1]) : -1;
  endfunction

  task automatic step(input logic en, input logic [1:0] p);
    in_en = en;
    pwm   = p;
    @(posedge clk);
    #1;
  endtask

  // Holds reset for two edges with an illegal code on the inputs, then releases it.
  task automatic do_reset();
    reset = 1'b0;
    step(1'b1, 2'b10);
    step(1'b1, 2'b10);
    reset = 1'b1;
    words.delete();
    stamps.delete();
  endtask

  task automatic drive_collect(input logic [1:0] a, input logic [1:0] b, input bit half,
                               input int nwords, output bit timeout);
    int s = 0;
    int c = 0;
    timeout = 1'b0;
    while (words.size() < nwords) begin
      if (c >= 400) begin
        timeout = 1'b1;
        break;
      end
      in_en = half ? ((c % 2) == 0) : 1'b1;
      pwm   = ((s % 2) == 0) ? a : b;
      if (in_en) s++;
      @(posedge clk);
      #1;
      c++;
    end
    in_en = 1'b0;
  endtask

  initial begin
    bit to;
    int n;

    //          a      b      half w1    w2     w3     gap
    vecs[0] = '{2'b00, 2'b00, 1'b0, 0,    0,     0,     32};
    vecs[1] = '{2'b01, 2'b01, 1'b0, 528,  1023,  1023,  32};
    vecs[2] = '{2'b11, 2'b11, 1'b0, -528, -1024, -1024, 32};
    vecs[3] = '{2'b01, 2'b00, 1'b0, 272,  512,   512,   32};
    vecs[4] = '{2'b01, 2'b00, 1'b1, 272,  512,   512,   64};
    vecs[5] = '{2'b11, 2'b00, 1'b0, -272, -512,  -512,  32};
    vecs[6] = '{2'b01, 2'b11, 1'b0, 16,   0,     0,     32};

    reset      = 1'b0;
    in_en      = 1'b0;
    pwm        = 2'b00;
    dout_ready = 1'b1;
    @(posedge clk);
    #1;

    // Reset state, with pwm=10 and in_en=1 presented during reset.
    reset = 1'b0;
    step(1'b1, 2'b10);
    step(1'b1, 2'b10);
    chk("rst_dout", int'(dout), 0);
    chk("rst_valid", int'(dout_valid), 0);
    chk("rst_ovf", int'(ovf), 0);
    chk("rst_err", int'(err), 0);

    for (int v = 0; v < 7; v++) begin
      do_reset();
      drive_collect(vecs[v].a, vecs[v].b, vecs[v].half, 3, to);
      chk($sformatf("v%0d_timeout", v), int'(to), 0);
      chk($sformatf("v%0d_w1", v), word_at(0), vecs[v].w1);
      chk($sformatf("v%0d_w2", v), word_at(1), vecs[v].w2);
      chk($sformatf("v%0d_w3", v), word_at(2), vecs[v].w3);
      chk($sformatf("v%0d_gap", v), gap_at(2), vecs[v].gap);
      chk($sformatf("v%0d_flags", v), int'({ovf, err}), 0);
    end

    // Single illegal code: err sticks, sample contributes nothing.
    do_reset();
    for (int c = 0; c < 140; c++) begin
      step(1'b1, (c == 5) ? 2'b10 : 2'b00);
      if (c == 8) chk("err_set", int'(err), 1);
    end
    chk("err_held", int'(err), 1);
    chk("err_w1", word_at(0), 0);
    chk("err_w2", word_at(1), 0);
    chk("err_w3", word_at(2), 0);
    chk("err_ovf", int'(ovf), 0);

    // Consumer stalls across two decimation edges.
    do_reset();
    dout_ready = 1'b0;
    n = 0;
    while (!dout_valid && n < 100) begin
      step(1'b1, 2'b01);
      n++;
    end
    chk("ovf_first_valid", int'(dout_valid), 1);
    chk("ovf_first_word", int'(dout), 528);
    chk("ovf_before", int'(ovf), 0);
    step(1'b1, 2'b01);
    chk("ovf_stable_word", int'(dout), 528);
    n = 0;
    while (!ovf && n < 100) begin
      step(1'b1, 2'b01);
      n++;
    end
    chk("ovf_set", int'(ovf), 1);
    chk("ovf_word", int'(dout), 1023);
    chk("ovf_valid", int'(dout_valid), 1);
    dout_ready = 1'b1;
    step(1'b1, 2'b01);
    dout_ready = 1'b0;
    chk("ovf_consumed", int'(dout_valid), 0);
    step(1'b1, 2'b01);
    chk("ovf_sticky", int'(ovf), 1);

    // Reset for one cycle while a word is pending.
    n = 0;
    while (!dout_valid && n < 100) begin
      step(1'b1, 2'b01);
      n++;
    end
    chk("mid_pending", int'(dout_valid), 1);
    reset = 1'b0;
    step(1'b1, 2'b01);
    chk("mid_dout", int'(dout), 0);
    chk("mid_valid", int'(dout_valid), 0);
    chk("mid_ovf", int'(ovf), 0);
    chk("mid_err", int'(err), 0);
    reset      = 1'b1;
    dout_ready = 1'b1;
    words.delete();
    stamps.delete();
    drive_collect(2'b01, 2'b01, 1'b0, 2, to);
    chk("mid_timeout", int'(to), 0);
    chk("mid_w1", word_at(0), 528);
    chk("mid_w2", word_at(1), 1023);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
